// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device-side link.
// Odd-parity helper is used by the TX framer and the optional RX check.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_RX,
    ST_ACK,
    ST_HOLDOFF
  } ps2_dev_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_RX_BITS    = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_bit_timer.sv
// Free-running HALF_PERIOD down-counter; phase_done marks the last
// cycle of each half-phase, and load restarts a fresh half-phase.
module ps2_bit_timer #(
  parameter int HALF_PERIOD = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_done
);

  localparam logic [11:0] RELOAD = 12'(HALF_PERIOD - 1);

  logic [11:0] cnt_q, cnt_d;

  assign phase_done = (cnt_q == 12'd0);

  always_comb begin
    cnt_d = cnt_q - 12'd1;
    if (load || phase_done) cnt_d = RELOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_device.sv
// PS/2 device-side link: clock generation, TX framing, RX with ACK.
// Define PS2_DEVICE_PARITY_CHECK_EN to reject host bytes with bad parity.
module ps2_device
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_d,
  input  logic       ps2_data_d,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       ps2_clk_q,
  output logic       ps2_data_q,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       tx_ready
);

  localparam logic [3:0] TX_LAST = 4'(PS2_FRAME_BITS - 1);
  localparam logic [3:0] RX_LAST = 4'(PS2_RX_BITS - 1);

  ps2_dev_state_t state_q, state_d;

  logic [1:0] clk_sync_q, data_sync_q;
  logic       ps2_clk_s, ps2_data_s;
  logic       phase_q, phase_d;
  logic [3:0] bit_q, bit_d, bit_nxt;
  logic       clk_drv_q, clk_drv_d;
  logic       dat_drv_q, dat_drv_d;
  logic       pending_q, pending_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_data_q;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_req_q, tx_req_qq, tx_rise;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_stop_q, rx_stop_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_ready_q, rx_ready_d;
  logic       rx_error_q, rx_error_d;
  logic       tmr_load, phase_done;
  logic       rx_sample, rx_bad, both_high;
  logic [10:0] tx_frame;

  ps2_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .phase_done(phase_done)
  );

  assign ps2_clk_s  = clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];
  assign both_high  = ps2_clk_s & ps2_data_s;
  assign tx_rise    = tx_req_q & ~tx_req_qq;
  assign bit_nxt    = bit_q + 4'd1;
  assign tx_frame   = {1'b1, odd_parity(tx_byte_q), tx_byte_q, 1'b0};

  assign rx_sample = (state_q == ST_RX) && phase_done
                   && !phase_q && ps2_clk_s;

`ifdef PS2_DEVICE_PARITY_CHECK_EN
  logic rx_par_q;
  always_ff @(posedge clk) begin
    if (rst)                           rx_par_q <= 1'b0;
    else if (rx_sample && bit_q == 4'd8) rx_par_q <= ps2_data_s;
  end
  assign rx_bad = !rx_stop_q || (rx_par_q != odd_parity(rx_byte_q));
`else
  assign rx_bad = !rx_stop_q;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    clk_drv_d  = clk_drv_q;
    dat_drv_d  = dat_drv_q;
    pending_d  = pending_q;
    tx_byte_d  = tx_byte_q;
    rx_byte_d  = rx_byte_q;
    rx_stop_d  = rx_stop_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    rx_error_d = 1'b0;
    tmr_load   = 1'b0;

    if (tx_rise && tx_ready_q) begin
      pending_d = 1'b1;
      tx_byte_d = tx_data_q;
    end

    if (rx_sample) begin
      if (bit_q < 4'd8)       rx_byte_d[bit_q[2:0]] = ps2_data_s;
      else if (bit_q == RX_LAST) rx_stop_d = ps2_data_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        // Host request-to-send outranks a pending TX byte
        if (ps2_clk_s && !ps2_data_s) begin
          state_d  = ST_RX;
          tmr_load = 1'b1;
          phase_d  = 1'b0;
          bit_d    = 4'd0;
        end else if (pending_q && both_high) begin
          state_d   = ST_TX;
          tmr_load  = 1'b1;
          phase_d   = 1'b0;
          bit_d     = 4'd0;
          dat_drv_d = ~tx_frame[0];
        end
      end
      ST_TX, ST_RX: begin
        if (phase_done && !phase_q) begin
          if (!ps2_clk_s) begin
            state_d   = ST_HOLDOFF;
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            tmr_load  = 1'b1;
          end else begin
            phase_d   = 1'b1;
            clk_drv_d = 1'b1;
          end
        end else if (phase_done) begin
          clk_drv_d = 1'b0;
          phase_d   = 1'b0;
          if (state_q == ST_TX) begin
            if (bit_q == TX_LAST) begin
              state_d   = ST_HOLDOFF;
              dat_drv_d = 1'b0;
              pending_d = 1'b0;
              tmr_load  = 1'b1;
            end else begin
              bit_d     = bit_nxt;
              dat_drv_d = ~tx_frame[bit_nxt];
            end
          end else if (bit_q == RX_LAST) begin
            bit_d = 4'd0;
            if (rx_bad) begin
              state_d    = ST_HOLDOFF;
              rx_error_d = 1'b1;
              tmr_load   = 1'b1;
            end else begin
              state_d   = ST_ACK;
              dat_drv_d = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
          end
        end
      end
      ST_ACK: begin
        if (phase_done && !phase_q) begin
          phase_d   = 1'b1;
          clk_drv_d = 1'b1;
        end else if (phase_done) begin
          phase_d    = 1'b0;
          clk_drv_d  = 1'b0;
          dat_drv_d  = 1'b0;
          rx_data_d  = rx_byte_q;
          rx_ready_d = 1'b1;
          state_d    = ST_HOLDOFF;
          tmr_load   = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        // Two half-phases of continuously idle lines
        if (!both_high) begin
          tmr_load = 1'b1;
          phase_d  = 1'b0;
        end else if (phase_done) begin
          if (phase_q) state_d = ST_IDLE;
          phase_d = ~phase_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
      end
    endcase

    tx_ready_d = ~pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      phase_q     <= 1'b0;
      bit_q       <= 4'd0;
      clk_drv_q   <= 1'b0;
      dat_drv_q   <= 1'b0;
      pending_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_data_q   <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_req_q    <= 1'b0;
      tx_req_qq   <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_stop_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_d};
      data_sync_q <= {data_sync_q[0], ps2_data_d};
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      clk_drv_q   <= clk_drv_d;
      dat_drv_q   <= dat_drv_d;
      pending_q   <= pending_d;
      tx_ready_q  <= tx_ready_d;
      tx_data_q   <= tx_data;
      tx_byte_q   <= tx_byte_d;
      tx_req_q    <= tx_req;
      tx_req_qq   <= tx_req_q;
      rx_byte_q   <= rx_byte_d;
      rx_stop_q   <= rx_stop_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign ps2_clk_q  = clk_drv_q;
  assign ps2_data_q = dat_drv_q;
  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign rx_error   = rx_error_q;
  assign tx_ready   = tx_ready_q;

endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device with a wired-AND host model.
// Vector table for single frames, hand sequences for multi-frame cases.
module tb_ps2_device;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2_clk_d, ps2_data_d;
  logic       ps2_clk_q, ps2_data_q;
  logic [7:0] rx_data;
  logic       rx_ready, rx_error, tx_ready;

  always #5 clk = ~clk;

  assign ps2_clk_d  = ~(ps2_clk_q | host_clk_low);
  assign ps2_data_d = ~(ps2_data_q | host_data_low);

  ps2_device #(.HALF_PERIOD(HP)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_d (ps2_clk_d),
    .ps2_data_d(ps2_data_d),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .ps2_clk_q (ps2_clk_q),
    .ps2_data_q(ps2_data_q),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_error  (rx_error),
    .tx_ready  (tx_ready)
  );

  int total = 0;
  int bad = 0;
  int n_ready = 0;
  int n_error = 0;
  int n_both = 0;
  int n_rise = 0;
  logic clk_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_ready) n_ready++;
    if (rx_error) n_error++;
    if (rx_ready && rx_error) n_both++;
    if (ps2_clk_q && !clk_prev) n_rise++;
    clk_prev = ps2_clk_q;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input logic v, output bit ok);
    int t;
    t = 0;
    while (ps2_clk_q !== v && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (ps2_clk_q === v);
  endtask

  task automatic tx_pulse(input logic [7:0] d);
    tx_data = d;
    tx_req  = 1'b1;
    repeat (2) @(negedge clk);
    tx_req  = 1'b0;
  endtask

  task automatic tx_recv(output logic [10:0] fr, output int lo_min,
                         output int lo_max, output bit ok);
    bit w;
    int n;
    fr = '0;
    lo_min = 999;
    lo_max = 0;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_clk(1'b1, w);
      if (!w) begin
        ok = 1'b0;
        break;
      end
      fr[i] = ~ps2_data_q;
      n = 0;
      while (ps2_clk_q === 1'b1 && n < 300) begin
        n++;
        @(negedge clk);
      end
      if (n < lo_min) lo_min = n;
      if (n > lo_max) lo_max = n;
    end
  endtask

  task automatic host_send(input logic [7:0] b, input logic par,
                           input logic stp, output int ack,
                           output bit ok);
    logic [9:0] bits;
    bit w;
    int t;
    bits = {stp, par, b};
    ok = 1'b1;
    ack = 0;
    host_data_low = 1'b1;
    repeat (3) @(negedge clk);
    host_data_low = ~bits[0];
    for (int k = 1; k <= 10; k++) begin
      wait_clk(1'b1, w);
      if (!w) begin
        ok = 1'b0;
        break;
      end
      if (k < 10) host_data_low = ~bits[k];
      else        host_data_low = 1'b0;
      wait_clk(1'b0, w);
    end
    host_data_low = 1'b0;
    t = 0;
    while (t < 200 && !rx_ready && !rx_error) begin
      if (ps2_data_q) ack++;
      @(negedge clk);
      t++;
    end
    if (t >= 200) ok = 1'b0;
  endtask

  typedef struct {
    bit         is_rx;
    logic [7:0] d;
    logic       par;
    logic       stp;
    int         exp_ack;
    int         exp_rdy;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [10:0] fr;
    int mn, mx, ack, r0, e0, c0;
    bit ok;

    vecs[0] = '{1'b0, 8'hAA, 1'b1, 1'b1, 0, 0, 0};
    vecs[1] = '{1'b0, 8'h01, 1'b0, 1'b1, 0, 0, 0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 0, 0};
    vecs[3] = '{1'b1, 8'hED, 1'b1, 1'b1, 8, 1, 0};
`ifdef PS2_DEVICE_PARITY_CHECK_EN
    vecs[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 0, 0, 1};
`else
    vecs[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 8, 1, 0};
`endif
    vecs[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 0, 1};
    vecs[6] = '{1'b1, 8'h81, 1'b1, 1'b1, 8, 1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clk_q", 32'(ps2_clk_q), 0);
    check("rst_data_q", 32'(ps2_data_q), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_rx_error", 32'(rx_error), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!vecs[i].is_rx) begin
        tx_pulse(vecs[i].d);
        check($sformatf("v%0d_tx_busy", i), 32'(tx_ready), 0);
        tx_recv(fr, mn, mx, ok);
        check($sformatf("v%0d_tx_done", i), 32'(ok), 1);
        check($sformatf("v%0d_frame", i), 32'(fr),
              32'({1'b1, vecs[i].par, vecs[i].d, 1'b0}));
        check($sformatf("v%0d_low_min", i), 32'(mn), HP);
        check($sformatf("v%0d_low_max", i), 32'(mx), HP);
        check($sformatf("v%0d_tx_ready", i), 32'(tx_ready), 1);
      end else begin
        r0 = n_ready;
        e0 = n_error;
        host_send(vecs[i].d, vecs[i].par, vecs[i].stp, ack, ok);
        repeat (20) @(negedge clk);
        check($sformatf("v%0d_rx_done", i), 32'(ok), 1);
        check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
        check($sformatf("v%0d_ready", i), 32'(n_ready - r0),
              32'(vecs[i].exp_rdy));
        check($sformatf("v%0d_error", i), 32'(n_error - e0),
              32'(vecs[i].exp_err));
        if (vecs[i].exp_rdy == 1)
          check($sformatf("v%0d_rx_data", i), 32'(rx_data),
                32'(vecs[i].d));
      end
      repeat (20) @(negedge clk);
    end

    // Host inhibit during bit 5, then full retransmission
    @(negedge clk);
    tx_pulse(8'hAA);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit w;
      wait_clk(1'b1, w);
      if (!w) ok = 1'b0;
      if (i < 5) begin
        wait_clk(1'b0, w);
        if (!w) ok = 1'b0;
      end
    end
    check("inh_reach_bit5", 32'(ok), 1);
    host_clk_low = 1'b1;
    repeat (30) @(negedge clk);
    check("inh_clk_rel", 32'(ps2_clk_q), 0);
    check("inh_data_rel", 32'(ps2_data_q), 0);
    check("inh_pending", 32'(tx_ready), 0);
    host_clk_low = 1'b0;
    tx_recv(fr, mn, mx, ok);
    check("inh_retx_done", 32'(ok), 1);
    check("inh_retx_frame", 32'(fr), 32'(11'b1_1_10101010_0));
    check("inh_tx_ready", 32'(tx_ready), 1);
    repeat (20) @(negedge clk);

    // Collision: RX wins, pending TX follows, second request ignored
    @(negedge clk);
    r0 = n_ready;
    tx_data = 8'hAA;
    tx_req = 1'b1;
    host_send(8'hED, 1'b1, 1'b1, ack, ok);
    check("col_rx_done", 32'(ok), 1);
    check("col_rx_ack", 32'(ack), 8);
    check("col_rx_data", 32'(rx_data), 32'h00ED);
    tx_req = 1'b0;
    @(negedge clk);
    tx_pulse(8'h55);
    tx_recv(fr, mn, mx, ok);
    check("col_tx_done", 32'(ok), 1);
    check("col_tx_frame", 32'(fr), 32'(11'b1_1_10101010_0));
    check("col_ready_cnt", 32'(n_ready - r0), 1);
    c0 = n_rise;
    repeat (80) @(negedge clk);
    check("col_no_second", 32'(n_rise - c0), 0);
    check("col_tx_ready", 32'(tx_ready), 1);

    // Reset in the middle of a TX frame
    @(negedge clk);
    tx_pulse(8'hAA);
    repeat (12) @(negedge clk);
    check("rstm_busy", 32'(ps2_data_q), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_clk_q", 32'(ps2_clk_q), 0);
    check("rstm_data_q", 32'(ps2_data_q), 0);
    check("rstm_tx_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    c0 = n_rise;
    repeat (80) @(negedge clk);
    check("rstm_lost", 32'(n_rise - c0), 0);

    check("pulse_overlap", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
